// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the 8:1 bus mux select; grants one lane at a time.
// Define RR_MUX_ARB_BURST_LIMIT_EN to release a grant after MAX_BURST beats.
module rr_mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] din,
  input  logic               dout_ready,
  output logic [7:0]         gnt,
  output logic [2:0]         sel,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  output logic               busy
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
`ifdef RR_MUX_ARB_BURST_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_e     state_q;
  logic [7:0] gnt_q;
  logic [2:0] sel_q;
  logic [2:0] ptr_q;
  logic [7:0] beat_cnt_q;

  logic [WIDTH-1:0] lane [8];
  logic [2:0]       win_d;
  logic [2:0]       scan_idx;
  logic             win_found;
  logic             beat;
  logic             release_d;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign lane[i] = din[WIDTH*i +: WIDTH];
  end

  // First requesting lane at or after ptr, wrapping 7 -> 0.
  always_comb begin
    win_d     = ptr_q;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = ptr_q + 3'(k);
      if (!win_found && req[scan_idx]) begin
        win_d     = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    if (state_q == BUSY) begin
      dout       = lane[sel_q];
      dout_valid = req[sel_q];
    end
  end

  assign beat      = dout_valid & dout_ready;
  assign release_d = !req[sel_q] || (LIMIT_EN && beat && (beat_cnt_q == BURST_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            sel_q      <= win_d;
            gnt_q      <= 8'b1 << win_d;
            beat_cnt_q <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (beat) beat_cnt_q <= beat_cnt_q + 8'd1;
          // Priority rotates past the lane just served, so it goes last next round.
          if (release_d) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= sel_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = (state_q == BUSY);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: vector table, directed corner cases,
// randomized traffic against a behavioural round-robin model.
module tb_rr_mux_arbiter;
  localparam int W  = 8;
  localparam int MB = 4;
`ifdef RR_MUX_ARB_BURST_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     req = '0;
  logic [8*W-1:0] din = '0;
  logic           dout_ready = 1'b0;
  logic [7:0]     gnt;
  logic [2:0]     sel;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           busy;

  int tests_run = 0;
  int tests_failed = 0;
  int m_owner, m_ptr, m_beats;

  typedef struct {
    logic [7:0]   req;
    logic [7:0]   gnt;
    logic [2:0]   sel;
    logic [W-1:0] dout;
    logic         dv;
    logic         busy;
  } vec_t;
  vec_t tbl [14];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .dout_ready(dout_ready),
    .gnt(gnt), .sel(sel), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane_val(input int i);
    return (i == 3) ? 8'hA5 : 8'(i * 17 + 1);
  endfunction

  function automatic vec_t mk(input logic [7:0] r, input logic [7:0] g, input logic [2:0] s,
                              input logic [W-1:0] d, input logic v, input logic b);
    vec_t x;
    x.req = r; x.gnt = g; x.sel = s; x.dout = d; x.dv = v; x.busy = b;
    return x;
  endfunction

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic set_table_din();
    for (int i = 0; i < 8; i++) din[W*i +: W] = lane_val(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_owner = -1; m_ptr = 0; m_beats = 0;
  endtask

  task automatic model_check();
    logic [7:0] eg;
    logic [W-1:0] ed;
    logic ev;
    eg = '0; ed = '0; ev = 1'b0;
    if (m_owner >= 0) begin
      eg = 8'(1 << m_owner);
      ed = din[W*m_owner +: W];
      ev = req[m_owner];
      chk("rnd_sel", sel, 32'(m_owner));
    end
    chk("rnd_gnt", gnt, eg);
    chk("rnd_busy", busy, m_owner >= 0);
    chk("rnd_dout", dout, ed);
    chk("rnd_valid", dout_valid, ev);
    chk("rnd_onehot", $onehot0(gnt), 1);
  endtask

  task automatic model_step();
    bit xfer;
    if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = pick(req, m_ptr);
        m_beats = 0;
      end
    end else begin
      xfer = req[m_owner] && dout_ready;
      if (xfer) m_beats++;
      if (!req[m_owner] || (LIM && xfer && m_beats == MB)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    int beats;
    tbl[0]  = mk(8'h08, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
    tbl[1]  = mk(8'h08, 8'h08, 3'd3, 8'hA5, 1'b1, 1'b1);
    tbl[2]  = mk(8'h08, 8'h08, 3'd3, 8'hA5, 1'b1, 1'b1);
    tbl[3]  = mk(8'h08, 8'h08, 3'd3, 8'hA5, 1'b1, 1'b1);
    tbl[4]  = mk(8'h00, 8'h08, 3'd3, 8'hA5, 1'b0, 1'b1);
    tbl[5]  = mk(8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
    tbl[6]  = mk(8'h40, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
    tbl[7]  = mk(8'h00, 8'h40, 3'd6, 8'h67, 1'b0, 1'b1);
    tbl[8]  = mk(8'h81, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
    tbl[9]  = mk(8'h81, 8'h80, 3'd7, 8'h78, 1'b1, 1'b1);
    tbl[10] = mk(8'h01, 8'h80, 3'd7, 8'h78, 1'b0, 1'b1);
    tbl[11] = mk(8'h01, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
    tbl[12] = mk(8'h00, 8'h01, 3'd0, 8'h01, 1'b0, 1'b1);
    tbl[13] = mk(8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);

    // Reset values, with requests and data already present
    req = 8'hFF; dout_ready = 1'b1; set_table_din();
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);

    // Single request, release, wrap-around
    req = '0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      req = tbl[i].req;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
      chk($sformatf("tbl%0d_valid", i), dout_valid, tbl[i].dv);
      if (tbl[i].busy) chk($sformatf("tbl%0d_sel", i), sel, tbl[i].sel);
    end

    // Reset mid-burst on lane 5, then backpressure on lane 2
    req = '0; dout_ready = 1'b1;
    do_reset();
    @(posedge clk); #1 req = 8'h08;
    @(posedge clk); #1 req = 8'h00;
    @(posedge clk); #1 req = 8'h20;
    @(posedge clk); #1;
    @(negedge clk) chk("rst_pre_gnt", gnt, 8'h20);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt", gnt, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_dout", dout, 0);
    chk("rst_mid_valid", dout_valid, 0);
    @(negedge clk);
    req = 8'h24; dout_ready = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_gnt", gnt, 8'h04);
      chk("bp_sel", sel, 2);
      chk("bp_dout", dout, lane_val(2));
      chk("bp_valid", dout_valid, 1);
    end
    dout_ready = 1'b1; req = 8'h04;
`ifdef RR_MUX_ARB_BURST_LIMIT_EN
    beats = 0;
    for (int t = 0; t < 20 && busy; t++) begin
      if (dout_valid && dout_ready) beats++;
      @(negedge clk);
    end
    chk("bp_burst_beats", beats, MB);
    chk("bp_released", busy, 0);
    req = 8'h09;
    @(negedge clk) chk("bp_next_gnt", gnt, 8'h08);
`else
    repeat (3) @(negedge clk);
    req = 8'h09;
    @(negedge clk) chk("bp_released", busy, 0);
    @(negedge clk) chk("bp_next_gnt", gnt, 8'h08);
`endif

`ifdef RR_MUX_ARB_BURST_LIMIT_EN
    // Full contention: 4 beats each, one idle cycle between grants
    req = 8'hFF; dout_ready = 1'b1;
    do_reset();
    for (int g = 0; g < 9; g++) begin
      repeat (MB) begin
        @(negedge clk);
        chk($sformatf("fc%0d_gnt", g), gnt, 8'(1 << (g % 8)));
        chk($sformatf("fc%0d_valid", g), dout_valid, 1);
      end
      @(negedge clk) chk($sformatf("fc%0d_idle", g), busy, 0);
    end
`else
    // No burst limit: lane 2 keeps the grant while lane 1 waits
    req = '0; dout_ready = 1'b1;
    do_reset();
    req = 8'h04;
    @(negedge clk) chk("hold_first_gnt", gnt, 8'h04);
    req = 8'h06;
    beats = 0;
    repeat (10) begin
      chk("hold_gnt", gnt, 8'h04);
      if (dout_valid && dout_ready) beats++;
      @(negedge clk);
    end
    chk("hold_beats", beats, 10);
    req = 8'h02;
    @(negedge clk) chk("hold_idle", busy, 0);
    @(negedge clk) chk("hold_next_gnt", gnt, 8'h02);
`endif

    // Randomized traffic against the reference model
    req = '0; dout_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      din = {$urandom, $urandom};
      dout_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      model_check();
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 8-input, 8-bit bus multiplexer. It drives the 3-bit select from registered grant state, steers the selected requester's data to a single downstream port with a valid/ready handshake, and rotates priority between transfers. It is the owner of the mux select in the datapath. No requester ever drives the select directly.

Parameters:
WIDTH, 8, data width of each requester lane and of dout.
MAX_BURST, 4, maximum accepted beats per grant; range 1..255. Used only when the optional feature is compiled in.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req  input  8  per-requester request; held high while the requester has beats to send.
din  input  8*WIDTH  packed lanes; lane i = din[WIDTH*i+WIDTH-1 : WIDTH*i].
dout_ready  input  1  downstream ready.
gnt  output  8  one-hot grant, registered; 0 when idle.
sel  output  3  registered mux select = index of the granted lane.
dout  output  WIDTH  lane[sel] while BUSY, else 0 (combinational 8:1 mux).
dout_valid  output  1  req[sel] while BUSY, else 0.
busy  output  1  high in BUSY state.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low; rst_n low clears state immediately without waiting for clk.
  - Reset values: state=IDLE, gnt=0, sel=0, busy=0, dout_valid=0, dout=0, ptr=0, beat_cnt=0.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - If req != 0, the winner is the first set bit at or after ptr, scanning upward mod 8 (7 wraps to 0).
  - Register sel=winner, gnt=1<<winner, beat_cnt=0, then go to BUSY.
  - Grant latency: req sampled high in cycle N gives gnt/busy high in cycle N+1.
  - If req == 0, stay in IDLE.
- BUSY:
  - A beat transfers on any edge where dout_valid && dout_ready.
  - Each transferred beat increments beat_cnt (8-bit).
  - While dout_ready is low, dout and dout_valid must be held stable; the beat count does not change.
- Release: leave BUSY for IDLE when either
  - req[sel] is sampled low, or
  - a beat transfers with beat_cnt == MAX_BURST-1 (feature on only).
- On release:
  - gnt=0 and busy=0 on the next edge.
  - ptr = (sel+1) mod 8.
  - There is always one IDLE cycle between consecutive grants.
- Simultaneous events:
  - req[sel] dropping on the same cycle the burst limit is hit counts as a single release; ptr advances once.
  - A requester dropping req while dout_ready is low releases with no beat transferred.
  - Requests arriving during BUSY wait; they are evaluated only in IDLE.
  - req changes of non-granted lanes never affect gnt or sel while BUSY.
- Reset mid-burst: outputs go to reset values asynchronously. After rst_n rises, arbitration restarts from ptr=0.
- Invariants:
  - gnt is always one-hot or zero.
  - sel always equals the index of the set gnt bit while busy.

Optional Feature:
- Macro: RR_MUX_ARB_BURST_LIMIT_EN.
- Defined: a grant is released after MAX_BURST transferred beats even if req[sel] stays high. The same requester may be re-granted only after all other requesting lanes have had their turn.
- Undefined:
  - Grant is held until req[sel] drops, with no beat limit.
  - beat_cnt still counts but is unused; MAX_BURST is ignored.

Test Plan:
1. Single request: ptr=0, req=8'h08 held 3 cycles, dout_ready=1, lane3=8'hA5.
   -> gnt=8'h08, sel=3, dout=8'hA5, dout_valid=1 from the next cycle; 3 beats transferred.
   -> After req drops: IDLE, ptr=4.
2. Full contention with macro on, MAX_BURST=4: req=8'hFF held, dout_ready=1.
   -> Grants 0,1,...,7,0 in order; exactly 4 beats each; one idle cycle between grants.
3. Wrap-around: grant lane 6 and release, then req=8'h81.
   -> Next grant is lane 7 (gnt=8'h80); the grant after that is lane 0 (gnt=8'h01).
4. Backpressure: lane 2 busy, dout_ready low for 3 cycles mid-burst.
   -> dout, dout_valid, sel and beat_cnt unchanged for those cycles; resumes when ready returns.
5. Reset mid-burst: lane 5 granted, 2 beats done, assert rst_n=0 between edges.
   -> gnt=0, busy=0, dout=0 immediately.
   -> After release with req=8'h24, lane 2 is granted first (ptr=0).
6. Macro off: req=8'h04 held for 10 beats while req[1] is also high.
   -> gnt stays 8'h04 for all 10 beats; lane 1 is granted only after req[2] drops.
